// File: rtl/lector_contadores.sv
// lector_contadores: sweeps the counter bank index 0..NUM_CNT-1 after an
// accepted start, captures each valid response into holding registers,
// accumulates their sum and flags timeouts/aborts.
//
// Ports:
//   clk      - system clock, rising edge
//   reset_L  - asynchronous active-low reset
//   idle     - datapath idle; counter bank answers only while high
//   start    - one-cycle sweep request (accepted only in IDLE with idle=1)
//   valid    - counter bank response valid
//   data_in  - counter value for the current idx
//   idx      - index presented to the counter bank
//   busy     - sweep in progress (SETTLE/WAIT)
//   done     - one-cycle pulse at end of sweep
//   error    - timeout or abort during last sweep (sticky until next start)
//   cnt_0..4 - captured counter values
//   total    - sum of captured values
module lector_contadores #(
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             idle,
    input  logic             start,
    input  logic             valid,
    input  logic [CNT_W-1:0] data_in,
    output logic [IDX_W-1:0] idx,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] cnt_0,
    output logic [CNT_W-1:0] cnt_1,
    output logic [CNT_W-1:0] cnt_2,
    output logic [CNT_W-1:0] cnt_3,
    output logic [CNT_W-1:0] cnt_4,
    output logic [7:0]       total
);

    localparam int unsigned NUM_CNT = 5;
    localparam int unsigned TOT_W   = 8;
    localparam int unsigned TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_d;
    logic               busy_d, done_d, error_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [TOT_W-1:0]   total_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CNT];
    logic [CNT_W-1:0]   cnt_d [NUM_CNT];
    logic               advance;
    logic               last_entry;

    // State and holding registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= S_IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            timer_q <= '0;
            total   <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx     <= idx_d;
            busy    <= busy_d;
            done    <= done_d;
            error   <= error_d;
            timer_q <= timer_d;
            total   <= total_d;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx;
        error_d    = error;
        timer_d    = timer_q;
        total_d    = total;
        advance    = 1'b0;
        last_entry = (idx == IDX_W'(NUM_CNT - 1));
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (start && idle) begin
                    for (int i = 0; i < NUM_CNT; i++) begin
                        cnt_d[i] = '0;
                    end
                    total_d = '0;
                    error_d = 1'b0;
                    idx_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!idle) begin
                    // Abort: current and remaining entries keep their cleared value.
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else if (valid) begin
                    for (int i = 0; i < NUM_CNT; i++) begin
                        if (idx == IDX_W'(i)) begin
                            cnt_d[i] = data_in;
                        end
                    end
                    total_d = total + TOT_W'(data_in);
                    advance = 1'b1;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    advance = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end

                if (advance) begin
                    if (last_entry) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx + IDX_W'(1);
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy/done are registered copies of the state being entered.
        busy_d = (state_d == S_SETTLE) || (state_d == S_WAIT);
        done_d = (state_d == S_DONE);
    end

    assign cnt_0 = cnt_q[0];
    assign cnt_1 = cnt_q[1];
    assign cnt_2 = cnt_q[2];
    assign cnt_3 = cnt_q[3];
    assign cnt_4 = cnt_q[4];

endmodule

// File: tb/tb_lector_contadores.sv
// Testbench for lector_contadores: builds a per-cycle timeline of each sweep
// from per-entry response plans, drives the bank side from it and checks
// busy/done/idx every cycle plus the captured results from done onwards.
module tb_lector_contadores;

    localparam int unsigned CNT_W   = 5;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned TIMEOUT = 4;
    localparam int          N       = 5;
    localparam int          MAXT    = 64;
    localparam int          NEVER   = 99;

    logic             clk = 1'b0;
    logic             reset_L;
    logic             idle, start, valid;
    logic [CNT_W-1:0] data_in;
    logic [IDX_W-1:0] idx;
    logic             busy, done, error;
    logic [CNT_W-1:0] cnt_0, cnt_1, cnt_2, cnt_3, cnt_4;
    logic [7:0]       total;

    always #5 clk = ~clk;

    lector_contadores #(.CNT_W(CNT_W), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_L(reset_L), .idle(idle), .start(start),
        .valid(valid), .data_in(data_in), .idx(idx), .busy(busy),
        .done(done), .error(error), .cnt_0(cnt_0), .cnt_1(cnt_1),
        .cnt_2(cnt_2), .cnt_3(cnt_3), .cnt_4(cnt_4), .total(total)
    );

    int checks = 0;
    int errors = 0;

    // Scenario: WAIT-cycle index at which each entry answers (NEVER = no answer),
    // whether valid is also shown in SETTLE, values, and optional abort point.
    int               lat [N];
    bit               sv  [N];
    logic [CNT_W-1:0] val [N];
    int               ab_ent, ab_k;

    // Timeline, indexed by cycles after the edge that accepts start.
    bit               s_idle  [MAXT];
    bit               s_valid [MAXT];
    bit               s_start [MAXT];
    logic [CNT_W-1:0] s_data  [MAXT];
    bit               e_busy  [MAXT];
    bit               e_done  [MAXT];
    int               e_idx   [MAXT];
    int               done_t;
    int               e_cnt   [N];
    int               e_total;
    bit               e_err;

    bit chk_en = 1'b0;
    int tcur   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0d got %0d expected %0d", name, tcur, act, exp);
        end
    endtask

    function automatic int get_cnt(input int i);
        case (i)
            0: return int'(cnt_0);
            1: return int'(cnt_1);
            2: return int'(cnt_2);
            3: return int'(cnt_3);
            default: return int'(cnt_4);
        endcase
    endfunction

    task automatic set_plan(input int l0, input int l1, input int l2, input int l3, input int l4,
                            input int v0, input int v1, input int v2, input int v3, input int v4);
        lat = '{l0, l1, l2, l3, l4};
        val = '{CNT_W'(v0), CNT_W'(v1), CNT_W'(v2), CNT_W'(v3), CNT_W'(v4)};
        sv  = '{0, 0, 0, 0, 0};
        ab_ent = -1;
        ab_k   = -1;
    endtask

    // Each entry: one SETTLE cycle, then WAIT cycles until answer, timeout or abort.
    task automatic build();
        int t;
        int last;
        bit stop;
        for (int j = 0; j < MAXT; j++) begin
            s_idle[j] = 1'b1; s_valid[j] = 1'b0; s_start[j] = 1'b0; s_data[j] = '0;
            e_busy[j] = 1'b0; e_done[j] = 1'b0; e_idx[j] = 0;
        end
        for (int i = 0; i < N; i++) e_cnt[i] = 0;
        t = 0; last = 0; stop = 1'b0; e_total = 0; e_err = 1'b0;
        for (int i = 0; i < N && !stop; i++) begin
            last = i;
            s_valid[t] = sv[i]; s_data[t] = val[i]; e_busy[t] = 1'b1; e_idx[t] = i;
            t++;
            for (int k = 0; k < int'(TIMEOUT); k++) begin
                e_busy[t] = 1'b1; e_idx[t] = i; s_data[t] = val[i];
                if (i == ab_ent && k == ab_k) begin
                    s_idle[t] = 1'b0; s_valid[t] = 1'b1; e_err = 1'b1; stop = 1'b1;
                    t++;
                    break;
                end
                if (k == lat[i]) begin
                    s_valid[t] = 1'b1; e_cnt[i] = int'(val[i]); e_total += int'(val[i]);
                    t++;
                    break;
                end
                t++;
                if (k == int'(TIMEOUT) - 1) e_err = 1'b1;
            end
        end
        done_t = t;
        e_done[t] = 1'b1;
        e_idx[t] = last;
    endtask

    // Per-cycle compare against the timeline.
    always @(negedge clk) begin
        if (chk_en && tcur < MAXT) begin
            chk("busy", int'(busy), int'(e_busy[tcur]));
            chk("done", int'(done), int'(e_done[tcur]));
            chk("idx", int'(idx), e_idx[tcur]);
            if (tcur >= done_t) begin
                for (int i = 0; i < N; i++) chk("cnt", get_cnt(i), e_cnt[i]);
                chk("total", int'(total), e_total);
                chk("error", int'(error), int'(e_err));
            end
        end
    end

    // Drive one sweep; reset_at >= 0 asserts reset inside that cycle instead.
    task automatic run_sweep(input int reset_at);
        @(posedge clk); #1;
        idle = 1'b1; start = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk_en = 1'b1;
        for (int t = 0; t <= done_t + 3; t++) begin
            tcur = t;
            idle = s_idle[t]; valid = s_valid[t]; data_in = s_data[t]; start = s_start[t];
            if (t == reset_at) begin
                chk_en = 1'b0;
                #2 reset_L = 1'b0;
                #1;
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_idx", int'(idx), 0);
                chk("rst_error", int'(error), 0);
                chk("rst_total", int'(total), 0);
                for (int i = 0; i < N; i++) chk("rst_cnt", get_cnt(i), 0);
                break;
            end
            @(posedge clk); #1;
        end
        chk_en = 1'b0;
        start = 1'b0; valid = 1'b0; idle = 1'b1;
    endtask

    initial begin
        reset_L = 1'b0; idle = 1'b0; start = 1'b0; valid = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_busy", int'(busy), 0);
        chk("init_total", int'(total), 0);
        chk("init_idx", int'(idx), 0);
        reset_L = 1'b1;

        // Normal sweep
        set_plan(0, 0, 0, 0, 0, 3, 0, 7, 31, 1);
        build();
        chk("model_done_t_normal", done_t, 10);
        chk("model_total_normal", e_total, 42);
        run_sweep(-1);
        chk("normal_cnt3", int'(cnt_3), 31);
        chk("normal_total", int'(total), 42);
        chk("normal_error", int'(error), 0);

        // Timeout on entry 2
        set_plan(0, 0, NEVER, 0, 0, 3, 0, 7, 31, 1);
        build();
        chk("model_done_t_timeout", done_t, 13);
        run_sweep(-1);
        chk("timeout_cnt2", int'(cnt_2), 0);
        chk("timeout_total", int'(total), 35);
        chk("timeout_error", int'(error), 1);

        // Abort while waiting on entry 1 (valid also high that cycle)
        set_plan(0, 0, 0, 0, 0, 3, 0, 7, 31, 1);
        ab_ent = 1; ab_k = 0;
        build();
        chk("model_done_t_abort", done_t, 4);
        run_sweep(-1);
        chk("abort_cnt0", int'(cnt_0), 3);
        chk("abort_total", int'(total), 3);
        chk("abort_error", int'(error), 1);

        // Delayed answers plus a start pulse mid-sweep that must be ignored
        set_plan(1, 0, 2, 0, 3, 9, 4, 17, 2, 30);
        build();
        s_start[3] = 1'b1;
        chk("model_done_t_delayed", done_t, 16);
        run_sweep(-1);
        chk("delayed_total", int'(total), 62);

        // Valid only in SETTLE for entry 3 -> timeout
        set_plan(0, 0, 0, NEVER, 0, 5, 6, 7, 8, 9);
        sv[3] = 1'b1;
        build();
        run_sweep(-1);
        chk("settle_valid_cnt3", int'(cnt_3), 0);
        chk("settle_valid_error", int'(error), 1);

        // Maximum sum
        set_plan(0, 3, 1, 0, 2, 31, 31, 31, 31, 31);
        build();
        chk("model_total_max", e_total, 155);
        run_sweep(-1);
        chk("max_total", int'(total), 155);
        chk("max_error", int'(error), 0);

        // start while datapath busy elsewhere (idle=0) is ignored
        @(posedge clk); #1;
        idle = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; idle = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("gate_busy", int'(busy), 0);
            chk("gate_done", int'(done), 0);
        end
        chk("gate_total_held", int'(total), 155);

        // Reset during WAIT of entry 2
        set_plan(0, 0, NEVER, 0, 0, 3, 4, 7, 31, 1);
        build();
        run_sweep(6);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_busy", int'(busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lector_contadores.md
# lector_contadores

Reader for the per-FIFO pop counters. When the datapath is idle and a `start` strobe arrives, the block walks `idx` over entries 0..NUM_CNT-1 and captures each `valid`/`data_in` response from the counter bank into holding registers. It also accumulates a total, flags timeouts and aborts, and pulses `done` when the sweep ends. It sits on the opposite side of the counter bank's `idx`/`valid`/`data_out` interface from the counter block itself, replacing the hand-driven `idx` sequence with hardware.

## Interface
- NUM_CNT, 5, number of counters read per sweep (fixed at 5 in this revision; one `cnt_N` port each)
- CNT_W, 5, counter data width
- IDX_W, 3, index width
- TIMEOUT, 4, WAIT cycles allowed per entry before timeout (≥1)

- clk  input  1  system clock, all state on rising edge
- reset_L  input  1  asynchronous, active-low reset
- idle  input  1  datapath idle; counter bank answers only while high
- start  input  1  one-cycle sweep request
- valid  input  1  counter bank response valid
- data_in  input  CNT_W  counter value for current `idx`
- idx  output  IDX_W  index presented to counter bank
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse at end of sweep
- error  output  1  sticky until next accepted start: timeout or abort occurred in last sweep
- cnt_0 … cnt_4  output  CNT_W each  captured counter values
- total  output  8  sum of captured values (max 5×31=155, no overflow)

## Operation
- Reset (async, reset_L=0): state IDLE; idx=0, busy=0, done=0, error=0, cnt_0..cnt_4=0, total=0, timer=0. Reset mid-sweep discards the sweep completely.
- States: IDLE, SETTLE, WAIT, DONE. `busy`=1 in SETTLE and WAIT only.
- IDLE: `start`=1 and `idle`=1 → clear cnt_*, total, error; idx←0; → SETTLE. `start` while `idle`=0 is ignored (no flag). `start` in any other state is ignored.
- SETTLE: one cycle for counter bank to see new `idx`; `valid` ignored; timer←0; → WAIT.
- WAIT, priority order:
  1. `idle`=0 → error←1, current and remaining entries keep value 0, → DONE (abort).
  2. `valid`=1 → cnt[idx]←data_in; total←total+data_in; then advance.
  3. timer==TIMEOUT-1 → cnt[idx] stays 0; error←1; advance.
  4. otherwise timer←timer+1.
- Advance: idx==NUM_CNT-1 → DONE; else idx←idx+1, → SETTLE.
- DONE: `done`=1 for exactly this cycle; idx←0; → IDLE. cnt_*, total, error hold until next accepted start.
- total is zero-extended addition of CNT_W-bit values into 8 bits.

## Timing
- `start` sampled at edge E0. Entry i captured at edge E0+2(i+1) when `valid` is present in the first WAIT cycle.
- Best case: last capture at E0+10; `done` high in the cycle after E0+10; `busy` falls at the same edge.
- Each timed-out entry adds TIMEOUT-1 cycles over best case. Worst case with no `valid`: 5×(1+TIMEOUT) cycles to DONE.
- idx changes only on edges entering SETTLE (or →0 on entering DONE→IDLE); stable throughout SETTLE+WAIT.
- `valid` asserted in SETTLE is never captured; only `valid` in WAIT counts.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: hold reset_L=0 mid-sweep (during WAIT, idx=2) → all outputs 0 immediately, busy=0; after release, no `done` until a new start.
- Normal sweep: idle=1, bank returns 3,0,7,31,1 with valid in each WAIT first cycle → done at E0+11 cycle, cnt_0..4=3,0,7,31,1, total=42, error=0.
- Timeout: entry 2 never valid, TIMEOUT=4 → cnt_2=0, error=1, others captured, done 3 cycles later than normal sweep.
- Abort: idle drops during WAIT for idx=1 → error=1, cnt_0 captured, cnt_1..4=0, done one cycle later, busy=0.
- Gating: start with idle=0 → stays IDLE, busy=0; start pulse during busy → ignored, sweep result unchanged; valid only in SETTLE cycle then absent → treated as timeout for that entry.
- Max sum: all five values 31 → total=155, error=0.
